// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state enum, the operand-forwarding select codes and a match helper.
package pipe_ctrl_pkg;

    localparam int MC_LAT_DEFAULT = 4;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // True when a valid source operand names the register a later stage is writing.
    function automatic logic src_hit(
        input logic       use_src,
        input logic [3:0] src_addr,
        input logic       wr_en,
        input logic [3:0] dst_addr
    );
        return use_src && wr_en && (src_addr == dst_addr);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for both E-stage sources.
// The M-stage result is younger than the W-stage one, so it takes priority.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       useA_E,
    input  logic       useB_E,
    input  logic [3:0] regA_addr_E,
    input  logic [3:0] regB_addr_E,
    input  logic       regw_M,
    input  logic [3:0] regDst_M,
    input  logic       regw_W,
    input  logic [3:0] regDst_W,
    output logic [1:0] fwdA_E,
    output logic [1:0] fwdB_E
);

    logic [1:0] use_src;
    logic [7:0] src_addr;
    logic [3:0] fwd_all;

    assign use_src  = {useB_E, useA_E};
    assign src_addr = {regB_addr_E, regA_addr_E};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            fwd_sel_t sel;

            always_comb begin
                sel = FWD_RF;
                if (src_hit(use_src[gi], src_addr[gi*4 +: 4], regw_M, regDst_M)) begin
                    sel = FWD_M;
                end else if (src_hit(use_src[gi], src_addr[gi*4 +: 4], regw_W, regDst_W)) begin
                    sel = FWD_W;
                end
            end

            assign fwd_all[gi*2 +: 2] = sel;
        end
    endgenerate

    assign fwdA_E = fwd_all[1:0];
    assign fwdB_E = fwd_all[3:2];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use stall, multi-cycle ALU hold
// and operand forwarding, plus a saturating count of decode-stall cycles.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LAT = MC_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  regA_addr_D,
    input  logic [3:0]  regB_addr_D,
    input  logic        useA_D,
    input  logic        useB_D,
    input  logic [3:0]  regA_addr_E,
    input  logic [3:0]  regB_addr_E,
    input  logic        useA_E,
    input  logic        useB_E,
    input  logic        regw_E,
    input  logic        regmem_E,
    input  logic [3:0]  regDst_E,
    input  logic        regw_M,
    input  logic        regw_W,
    input  logic [3:0]  regDst_M,
    input  logic [3:0]  regDst_W,
    input  logic        branch_taken_E,
    input  logic        mc_start_E,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_M,
    output logic [1:0]  fwdA_E,
    output logic [1:0]  fwdB_E,
    output logic [15:0] stall_cycles
);

    // The first hold cycle is spent in RUN and the release cycle at count zero,
    // so the counter starts two below the latency.
    localparam logic [3:0] MC_CNT_INIT = 4'(MC_LAT - 2);

    state_t      state_reg, state_next;
    logic [3:0]  mc_cnt_reg, mc_cnt_next;
    logic [15:0] stall_cycles_reg;
    logic        load_use;

    assign load_use = regmem_E && regw_E &&
                      ((useA_D && (regA_addr_D == regDst_E)) ||
                       (useB_D && (regB_addr_D == regDst_E)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= RUN;
            mc_cnt_reg       <= 4'd0;
            stall_cycles_reg <= 16'd0;
        end else begin
            state_reg  <= state_next;
            mc_cnt_reg <= mc_cnt_next;
            if (stall_D && (stall_cycles_reg != 16'hFFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 16'd1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        mc_cnt_next = mc_cnt_reg;
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        stall_E     = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        flush_M     = 1'b0;
        case (state_reg)
            RUN: begin
                if (branch_taken_E) begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                end else begin
                    if (load_use) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        // A held E stage must keep its op rather than take a bubble.
                        flush_E = !mc_start_E;
                    end
                    if (mc_start_E) begin
                        stall_F     = 1'b1;
                        stall_D     = 1'b1;
                        stall_E     = 1'b1;
                        flush_M     = 1'b1;
                        mc_cnt_next = MC_CNT_INIT;
                        state_next  = MC_WAIT;
                    end
                end
            end
            MC_WAIT: begin
                if (mc_cnt_reg != 4'd0) begin
                    stall_F     = 1'b1;
                    stall_D     = 1'b1;
                    stall_E     = 1'b1;
                    flush_M     = 1'b1;
                    mc_cnt_next = mc_cnt_reg - 4'd1;
                end else begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign stall_cycles = stall_cycles_reg;

    fwd_unit u_fwd (
        .useA_E      (useA_E),
        .useB_E      (useB_E),
        .regA_addr_E (regA_addr_E),
        .regB_addr_E (regB_addr_E),
        .regw_M      (regw_M),
        .regDst_M    (regDst_M),
        .regw_W      (regw_W),
        .regDst_W    (regDst_W),
        .fwdA_E      (fwdA_E),
        .fwdB_E      (fwdB_E)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MC_LAT, default 4, meaning cycles a multi-cycle ALU op occupies E (legal 2..16).
REQ-002 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports regA_addr_D, regB_addr_D  in  4 each  decode source registers; useA_D, useB_D  in  1 each  source valid.
REQ-005 The block SHALL have ports regA_addr_E, regB_addr_E  in  4 each; useA_E, useB_E  in  1 each  E-stage sources.
REQ-006 The block SHALL have ports regw_E, regmem_E  in  1 each  E writes reg / is load; regDst_E  in  4  E destination.
REQ-007 The block SHALL have ports regw_M, regw_W  in  1 each; regDst_M, regDst_W  in  4 each  M/W destinations.
REQ-008 The block SHALL have ports branch_taken_E  in  1  branch/pcload resolved taken in E; mc_start_E  in  1  E holds multi-cycle op.
REQ-009 The block SHALL have ports stall_F, stall_D, stall_E  out  1 each  hold stage register; flush_D, flush_E, flush_M  out  1 each  bubble into D/E/M register.
REQ-010 The block SHALL have ports fwdA_E, fwdB_E  out  2 each  operand select: 00 regfile, 01 W, 10 M.
REQ-011 The block SHALL have port stall_cycles  out  16  count of cycles with stall_D=1.

Function
REQ-012 FSM states SHALL be RUN and MC_WAIT; down-counter mc_cnt SHALL be 4 bits.
REQ-013 In RUN with branch_taken_E=1: flush_D=1, flush_E=1, all stalls 0, mc_start_E and load-use ignored, state stays RUN.
REQ-014 In RUN, load-use (regmem_E & regw_E & ((useA_D & regA_addr_D==regDst_E) | (useB_D & regB_addr_D==regDst_E))) without branch SHALL give stall_F=1, stall_D=1, flush_E=1 for that cycle only.
REQ-015 In RUN with mc_start_E=1 and no branch: stall_F/D/E=1, flush_M=1, mc_cnt<=MC_LAT-2, next state MC_WAIT.
REQ-016 In MC_WAIT with mc_cnt!=0: stall_F/D/E=1, flush_M=1, mc_cnt decrements; mc_start_E, branch_taken_E, load-use ignored.
REQ-017 In MC_WAIT with mc_cnt==0: all stalls and flushes 0, next state RUN; op thus occupies E exactly MC_LAT cycles.
REQ-018 Load-use and multi-cycle simultaneous in RUN: union of REQ-014 and REQ-015 outputs except flush_E=0 (E is held).
REQ-019 fwdA_E SHALL be 10 if useA_E & regw_M & regDst_M==regA_addr_E, else 01 if useA_E & regw_W & regDst_W==regA_addr_E, else 00; M beats W; fwdB_E identical on B.
REQ-020 Forwarding outputs SHALL be combinational and valid in every state.
REQ-021 stall_cycles SHALL increment each cycle stall_D=1 and saturate at 16'hFFFF.
REQ-022 All stall/flush outputs SHALL be combinational from state, mc_cnt and inputs; no output depends on a prior cycle except through state/mc_cnt.

Reset
REQ-023 rst_n=0 SHALL immediately force state RUN, mc_cnt 0, stall_cycles 0, independent of clk.
REQ-024 Reset asserted mid MC_WAIT SHALL abandon the op; first cycle after release behaves as RUN.
REQ-025 With all inputs 0 after reset every output SHALL be 0.

Structure
REQ-026 Package pipe_ctrl_pkg SHALL hold MC_LAT default, state enum (RUN, MC_WAIT), fwd select enum (FWD_RF, FWD_W, FWD_M).
REQ-027 Forwarding logic SHALL be sub-module fwd_unit (combinational, instantiated once, serves A and B).

Verification
REQ-028 Load-use: regmem_E=1, regw_E=1, regDst_E=3, useA_D=1, regA_addr_D=3 one cycle -> stall_F=stall_D=flush_E=1 that cycle, all 0 next, stall_cycles=1.
REQ-029 Multi-cycle: mc_start_E=1 held 4 cycles, MC_LAT=4 -> stall_E=1 and flush_M=1 on cycles 1-3, 0 on cycle 4, state RUN after.
REQ-030 Branch priority: branch_taken_E=1 with mc_start_E=1 and load-use -> flush_D=flush_E=1, stalls 0, state stays RUN.
REQ-031 Forwarding: regA_addr_E=5, useA_E=1, regw_M=1, regDst_M=5, regw_W=1, regDst_W=5 -> fwdA_E=10; drop regw_M -> 01; drop regw_W -> 00.
REQ-032 Reset mid-op: rst_n=0 during second MC_WAIT cycle -> all outputs 0 asynchronously, stall_cycles=0, RUN after release.
REQ-033 Saturation: stall_D forced via repeated load-use for 65537 cycles -> stall_cycles=16'hFFFF, no wrap.
